// File: rtl/seq_pattern_tx_pkg.sv
// Shared definitions for the serial frame transmitter: FSM states,
// the default sync word and a constant helper for counter sizing.
package seq_pattern_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        PAYLOAD,
        PARITY,
        GAP
    } state_t;

    localparam logic [3:0] DEFAULT_SYNC_WORD = 4'b1001;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/seq_pattern_tx_piso_shift.sv
// Parallel-in serial-out shift register: load a word, shift left, msb out.
module piso_shift #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] load_value,
    output logic         msb
);

    logic [W-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else if (load) begin
            sr <= load_value;
        end else if (shift) begin
            sr <= sr << 1;
        end
    end

    assign msb = sr[W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial frame transmitter: idle-low line, sync word, MSB-first payload,
// optional even parity, then a forced-low gap before returning to idle.
module seq_pattern_tx
    import seq_pattern_tx_pkg::*;
#(
    parameter int                SYNC_W    = 4,
    parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_W'(DEFAULT_SYNC_WORD),
    parameter int                DATA_W    = 8,
    parameter int                PARITY_EN = 0,
    parameter int                GAP_LEN   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] payload,
    output logic              ready,
    output logic              busy,
    output logic              data,
    output logic              done
);

    localparam int CW = $clog2(max3(SYNC_W, DATA_W, GAP_LEN) + 1);
    localparam logic [CW-1:0]     SYNC_LAST = CW'(SYNC_W - 1);
    localparam logic [CW-1:0]     DATA_LAST = CW'(DATA_W - 1);
    localparam logic [CW-1:0]     GAP_LAST  = CW'(GAP_LEN - 1);
    // The first sync bit goes straight onto the line at accept, so the
    // shifter only needs to hold the remaining ones.
    localparam logic [SYNC_W-1:0] SYNC_TAIL = SYNC_WORD << 1;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            parity_acc;
    logic            accept;
    logic            cnt_zero;
    logic            sync_shift;
    logic            pay_shift;
    logic            sync_msb;
    logic            pay_msb;

    assign ready      = (state == IDLE);
    assign accept     = ready && start;
    assign cnt_zero   = (cnt == '0);
    assign sync_shift = (state == SYNC) && !cnt_zero;
    assign pay_shift  = ((state == SYNC) && cnt_zero) || ((state == PAYLOAD) && !cnt_zero);

    piso_shift #(.W(SYNC_W)) u_sync (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .shift      (sync_shift),
        .load_value (SYNC_TAIL),
        .msb        (sync_msb)
    );

    piso_shift #(.W(DATA_W)) u_payload (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .shift      (pay_shift),
        .load_value (payload),
        .msb        (pay_msb)
    );

    // data is loaded one edge ahead with the bit for the coming cycle; cnt
    // counts the bits still to send in the current state after this one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            parity_acc <= 1'b0;
            data       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (pay_shift) begin
                parity_acc <= parity_acc ^ pay_msb;
            end
            case (state)
                IDLE: begin
                    data <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        state      <= SYNC;
                        cnt        <= SYNC_LAST;
                        parity_acc <= 1'b0;
                        data       <= SYNC_WORD[SYNC_W-1];
                        busy       <= 1'b1;
                    end
                end
                SYNC: begin
                    if (!cnt_zero) begin
                        data <= sync_msb;
                        cnt  <= cnt - 1'b1;
                    end else begin
                        state <= PAYLOAD;
                        data  <= pay_msb;
                        cnt   <= DATA_LAST;
                    end
                end
                PAYLOAD: begin
                    if (!cnt_zero) begin
                        data <= pay_msb;
                        cnt  <= cnt - 1'b1;
                    end else if (PARITY_EN != 0) begin
                        state <= PARITY;
                        data  <= parity_acc;
                    end else begin
                        state <= GAP;
                        data  <= 1'b0;
                        cnt   <= GAP_LAST;
                    end
                end
                PARITY: begin
                    state <= GAP;
                    data  <= 1'b0;
                    cnt   <= GAP_LAST;
                end
                GAP: begin
                    data <= 1'b0;
                    if (!cnt_zero) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    data  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: one instance without and one with parity, both
// compared against a frame-list reference model on every falling edge.
module tb_seq_pattern_tx;

    localparam int DATA_W  = 8;
    localparam int GAP_LEN = 2;

    logic             clk;
    logic             rst;
    logic             start;
    logic [DATA_W-1:0] payload;

    logic ready0, busy0, data0, done0;
    logic ready1, busy1, data1, done1;

    int errors = 0;
    int checks = 0;

    seq_pattern_tx #(.PARITY_EN(0)) dut0 (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .payload (payload),
        .ready   (ready0),
        .busy    (busy0),
        .data    (data0),
        .done    (done0)
    );

    seq_pattern_tx #(.PARITY_EN(1)) dut1 (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .payload (payload),
        .ready   (ready1),
        .busy    (busy1),
        .data    (data1),
        .done    (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: on accept, write out the whole frame (sync, payload,
    // optional parity, gap zeros) as a bit list, then replay one bit per cycle.
    bit exp_bits [2][32];
    int exp_len  [2];
    int exp_pos  [2];
    bit in_frame [2];
    bit exp_data [2];
    bit exp_busy [2];
    bit exp_done [2];

    always @(posedge clk or posedge rst) begin
        logic [3:0] sync_word;
        int n;
        sync_word = 4'b1001;
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                in_frame[m] = 1'b0;
                exp_data[m] = 1'b0;
                exp_busy[m] = 1'b0;
                exp_done[m] = 1'b0;
            end else if (in_frame[m]) begin
                if (exp_pos[m] == exp_len[m]) begin
                    in_frame[m] = 1'b0;
                    exp_data[m] = 1'b0;
                    exp_busy[m] = 1'b0;
                    exp_done[m] = 1'b1;
                end else begin
                    exp_data[m] = exp_bits[m][exp_pos[m]];
                    exp_pos[m]++;
                end
            end else begin
                exp_done[m] = 1'b0;
                if (start) begin
                    n = 0;
                    for (int i = 3; i >= 0; i--) exp_bits[m][n++] = sync_word[i];
                    for (int i = DATA_W - 1; i >= 0; i--) exp_bits[m][n++] = payload[i];
                    if (m == 1) exp_bits[m][n++] = ($countones(payload) % 2) == 1;
                    for (int i = 0; i < GAP_LEN; i++) exp_bits[m][n++] = 1'b0;
                    exp_len[m]  = n;
                    exp_data[m] = exp_bits[m][0];
                    exp_pos[m]  = 1;
                    exp_busy[m] = 1'b1;
                    in_frame[m] = 1'b1;
                end
            end
        end
    end

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s at %0t: observed=%b expected=%b", tag, $time, observed, expected);
        end
    endtask

    task automatic checkOutput(input string step);
        checkBit({step, " dut0 data"},  data0,  exp_data[0]);
        checkBit({step, " dut0 busy"},  busy0,  exp_busy[0]);
        checkBit({step, " dut0 ready"}, ready0, !in_frame[0]);
        checkBit({step, " dut0 done"},  done0,  exp_done[0]);
        checkBit({step, " dut1 data"},  data1,  exp_data[1]);
        checkBit({step, " dut1 busy"},  busy1,  exp_busy[1]);
        checkBit({step, " dut1 ready"}, ready1, !in_frame[1]);
        checkBit({step, " dut1 done"},  done1,  exp_done[1]);
    endtask

    // Drive inputs on the falling edge, then check each following falling edge.
    task automatic applyStimulus(input string step, input logic s, input logic [DATA_W-1:0] p,
                                 input int cycles);
        start   = s;
        payload = p;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            checkOutput(step);
        end
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        payload = '0;
        repeat (3) @(negedge clk);
        checkOutput("in reset");
        rst = 1'b0;

        $display("[TB] idle after reset");
        applyStimulus("idle", 1'b0, 8'h00, 10);

        $display("[TB] single frames A5 and 07");
        applyStimulus("frame A5", 1'b1, 8'hA5, 1);
        applyStimulus("frame A5", 1'b0, 8'h00, 18);
        applyStimulus("frame 07", 1'b1, 8'h07, 1);
        applyStimulus("frame 07", 1'b0, 8'h00, 18);

        $display("[TB] back-to-back frames with start held");
        applyStimulus("b2b", 1'b1, 8'h00, 1);
        applyStimulus("b2b", 1'b1, 8'hFF, 17);
        applyStimulus("b2b drain", 1'b0, 8'h00, 20);

        $display("[TB] start while busy is ignored");
        applyStimulus("ignore", 1'b1, 8'h5A, 1);
        applyStimulus("ignore", 1'b0, 8'h3C, 1);
        applyStimulus("ignore", 1'b1, 8'h3C, 1);
        applyStimulus("ignore", 1'b0, 8'h3C, 11);
        applyStimulus("ignore", 1'b1, 8'h3C, 1);
        applyStimulus("ignore", 1'b0, 8'h3C, 20);

        $display("[TB] asynchronous reset mid-payload");
        applyStimulus("abort", 1'b1, 8'hC3, 1);
        applyStimulus("abort", 1'b0, 8'h00, 7);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 checkOutput("async reset");
        @(negedge clk);
        checkOutput("held reset");
        rst = 1'b0;
        applyStimulus("after reset", 1'b1, 8'h96, 1);
        applyStimulus("after reset", 1'b0, 8'h00, 18);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus("random", ($urandom_range(0, 3) == 0), DATA_W'($urandom), 1);
        end
        applyStimulus("random drain", 1'b0, 8'h00, 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
